// File: rtl/dma_guard_pkg.sv
// Shared constants, FSM state types and the AXI burst window check
// for the DMA window guard.
package dma_guard_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT_R, ERR_R} rd_state_t;
    typedef enum logic [1:0] {PASS, WAIT_B, ERR_B} wr_state_t;

    // Widened to 65 bits so any carry past the address width lands above hi.
    function automatic logic win_legal(
        input logic [63:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst,
        input logic [64:0] lo,
        input logic [64:0] hi
    );
        logic [64:0] a;
        logic [64:0] bytes;
        logic [64:0] beat;
        logic [64:0] start;
        logic [64:0] last;
        a     = {1'b0, addr};
        bytes = ({57'd0, len} + 65'd1) << size;
        beat  = 65'd1 << size;
        start = (burst == BURST_WRAP) ? (a & ~(bytes - 65'd1)) : a;
        last  = (burst == BURST_FIXED) ? (a + beat - 65'd1)
                                       : (start + bytes - 65'd1);
        return (start >= lo) && (last <= hi);
    endfunction

endpackage

// File: rtl/dma_guard_win_chk.sv
// Combinational legality check of one AXI address beat against the
// fixed DMA window.
module dma_guard_win_chk
    import dma_guard_pkg::*;
#(
    parameter int                ADDR_W   = 40,
    parameter logic [ADDR_W-1:0] WIN_BASE = 40'h10_0000_0000,
    parameter logic [ADDR_W-1:0] WIN_SIZE = 40'h00_8000_0000
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [7:0]        len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic              legal_o
);

    localparam logic [64:0] LO = 65'(WIN_BASE);
    localparam logic [64:0] HI = 65'(WIN_BASE) + 65'(WIN_SIZE) - 65'd1;

    assign legal_o = win_legal(64'(addr_i), len_i, size_i, burst_i, LO, HI);

endmodule

// File: rtl/dma_window_guard.sv
// AXI4 firewall: forwards bursts inside the window, answers others with DECERR.
// Optional error log enabled by defining DMA_GUARD_ERRLOG_EN.
module dma_window_guard
    import dma_guard_pkg::*;
#(
    parameter int                ADDR_W   = 40,
    parameter logic [ADDR_W-1:0] WIN_BASE = 40'h10_0000_0000,
    parameter logic [ADDR_W-1:0] WIN_SIZE = 40'h00_8000_0000,
    parameter int                WQ_DEPTH = 8,
    parameter int                OUTS_W   = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
`ifdef DMA_GUARD_ERRLOG_EN
    input  logic              err_clr,
    output logic              err_irq,
    output logic [ADDR_W-1:0] err_addr,
    output logic              err_is_wr,
`endif
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awlock,
    input  logic [3:0]        s_axi_awcache,
    input  logic [2:0]        s_axi_awprot,
    input  logic [3:0]        s_axi_awqos,
    input  logic [15:0]       s_axi_awid,
    input  logic [15:0]       s_axi_awuser,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [63:0]       s_axi_wdata,
    input  logic [7:0]        s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [15:0]       s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arlock,
    input  logic [3:0]        s_axi_arcache,
    input  logic [2:0]        s_axi_arprot,
    input  logic [3:0]        s_axi_arqos,
    input  logic [15:0]       s_axi_arid,
    input  logic [15:0]       s_axi_aruser,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [63:0]       s_axi_rdata,
    output logic [15:0]       s_axi_rid,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awlock,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic [3:0]        m_axi_awqos,
    output logic [15:0]       m_axi_awid,
    output logic [15:0]       m_axi_awuser,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [63:0]       m_axi_wdata,
    output logic [7:0]        m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [15:0]       m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic [15:0]       m_axi_arid,
    output logic [15:0]       m_axi_aruser,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [63:0]       m_axi_rdata,
    input  logic [15:0]       m_axi_rid,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int PTR_W = $clog2(WQ_DEPTH);

    logic ar_legal, aw_legal;

    dma_guard_win_chk #(
        .ADDR_W(ADDR_W), .WIN_BASE(WIN_BASE), .WIN_SIZE(WIN_SIZE)
    ) u_ar_chk (
        .addr_i(s_axi_araddr), .len_i(s_axi_arlen),
        .size_i(s_axi_arsize), .burst_i(s_axi_arburst),
        .legal_o(ar_legal)
    );

    dma_guard_win_chk #(
        .ADDR_W(ADDR_W), .WIN_BASE(WIN_BASE), .WIN_SIZE(WIN_SIZE)
    ) u_aw_chk (
        .addr_i(s_axi_awaddr), .len_i(s_axi_awlen),
        .size_i(s_axi_awsize), .burst_i(s_axi_awburst),
        .legal_o(aw_legal)
    );

    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_awlock  = s_axi_awlock;
    assign m_axi_awcache = s_axi_awcache;
    assign m_axi_awprot  = s_axi_awprot;
    assign m_axi_awqos   = s_axi_awqos;
    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awuser  = s_axi_awuser;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;
    assign m_axi_arlock  = s_axi_arlock;
    assign m_axi_arcache = s_axi_arcache;
    assign m_axi_arprot  = s_axi_arprot;
    assign m_axi_arqos   = s_axi_arqos;
    assign m_axi_arid    = s_axi_arid;
    assign m_axi_aruser  = s_axi_aruser;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;

    // ---------------- read path ----------------
    rd_state_t         rd_state_q, rd_state_d;
    logic [OUTS_W-1:0] rd_outs_q, rd_outs_d;
    logic [15:0]       rd_id_q, rd_id_d;
    logic [7:0]        rd_len_q, rd_len_d;
    logic [7:0]        rd_cnt_q, rd_cnt_d;
    logic              rd_full, ar_viol, err_last, ar_rdy, ar_vld, r_rdy;

    assign rd_full = &rd_outs_q;

    always_comb begin
        rd_state_d   = rd_state_q;
        rd_id_d      = rd_id_q;
        rd_len_d     = rd_len_q;
        rd_cnt_d     = rd_cnt_q;
        ar_vld       = 1'b0;
        ar_rdy       = 1'b0;
        ar_viol      = 1'b0;
        r_rdy        = s_axi_rready;
        err_last     = (rd_cnt_q == rd_len_q);
        s_axi_rvalid = m_axi_rvalid;
        s_axi_rdata  = m_axi_rdata;
        s_axi_rid    = m_axi_rid;
        s_axi_rresp  = m_axi_rresp;
        s_axi_rlast  = m_axi_rlast;
        unique case (rd_state_q)
            IDLE: begin
                if (s_axi_arvalid) begin
                    if (ar_legal) begin
                        ar_vld = !rd_full;
                        ar_rdy = m_axi_arready && !rd_full;
                    end else begin
                        ar_rdy     = 1'b1;
                        ar_viol    = 1'b1;
                        rd_id_d    = s_axi_arid;
                        rd_len_d   = s_axi_arlen;
                        rd_cnt_d   = '0;
                        rd_state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (rd_outs_q == '0) rd_state_d = ERR_R;
            end
            ERR_R: begin
                s_axi_rvalid = 1'b1;
                s_axi_rdata  = '0;
                s_axi_rid    = rd_id_q;
                s_axi_rresp  = RESP_DECERR;
                s_axi_rlast  = err_last;
                r_rdy        = 1'b0;
                if (s_axi_rready) begin
                    if (err_last) rd_state_d = IDLE;
                    else          rd_cnt_d   = rd_cnt_q + 8'd1;
                end
            end
            default: rd_state_d = IDLE;
        endcase
    end

    assign m_axi_arvalid = ar_vld;
    assign s_axi_arready = ar_rdy;
    assign m_axi_rready  = r_rdy;

    logic rd_inc, rd_dec;
    assign rd_inc = ar_vld && m_axi_arready;
    assign rd_dec = m_axi_rvalid && r_rdy && m_axi_rlast;

    always_comb begin
        rd_outs_d = rd_outs_q;
        if (rd_inc && !rd_dec) rd_outs_d = rd_outs_q + OUTS_W'(1);
        if (!rd_inc && rd_dec) rd_outs_d = rd_outs_q - OUTS_W'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state_q <= IDLE;
            rd_outs_q  <= '0;
            rd_id_q    <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_outs_q  <= rd_outs_d;
            rd_id_q    <= rd_id_d;
            rd_len_q   <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // ---------------- write path ----------------
    wr_state_t         wr_state_q, wr_state_d;
    logic [OUTS_W-1:0] wr_outs_q, wr_outs_d;
    logic [15:0]       wr_id_q, wr_id_d;
    logic [WQ_DEPTH-1:0] fifo_blk_q;
    logic [15:0]       fifo_id_q [WQ_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [PTR_W:0]    fcnt_q;
    logic              fifo_empty, fifo_full, head_blk, push, pop, can_push;
    logic              wr_full, aw_viol, aw_vld, aw_rdy, w_vld, w_rdy, b_rdy;

    assign fifo_empty = (fcnt_q == '0);
    assign fifo_full  = (fcnt_q == (PTR_W+1)'(WQ_DEPTH));
    assign head_blk   = fifo_blk_q[rptr_q];
    assign wr_full    = &wr_outs_q;

    always_comb begin
        wr_state_d   = wr_state_q;
        wr_id_d      = wr_id_q;
        w_vld        = 1'b0;
        w_rdy        = 1'b0;
        pop          = 1'b0;
        b_rdy        = s_axi_bready;
        s_axi_bvalid = m_axi_bvalid;
        s_axi_bid    = m_axi_bid;
        s_axi_bresp  = m_axi_bresp;
        unique case (wr_state_q)
            PASS: begin
                if (!fifo_empty) begin
                    if (head_blk) begin
                        w_rdy = 1'b1;
                    end else begin
                        w_vld = s_axi_wvalid;
                        w_rdy = m_axi_wready;
                    end
                    if (s_axi_wvalid && w_rdy && s_axi_wlast) begin
                        pop = 1'b1;
                        if (head_blk) begin
                            wr_id_d    = fifo_id_q[rptr_q];
                            wr_state_d = WAIT_B;
                        end
                    end
                end
            end
            WAIT_B: begin
                if (wr_outs_q == '0) wr_state_d = ERR_B;
            end
            ERR_B: begin
                s_axi_bvalid = 1'b1;
                s_axi_bid    = wr_id_q;
                s_axi_bresp  = RESP_DECERR;
                b_rdy        = 1'b0;
                if (s_axi_bready) wr_state_d = PASS;
            end
            default: wr_state_d = PASS;
        endcase
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign can_push = !fifo_full || pop;

    always_comb begin
        aw_vld  = 1'b0;
        aw_rdy  = 1'b0;
        aw_viol = 1'b0;
        if (s_axi_awvalid && can_push) begin
            if (aw_legal) begin
                aw_vld = !wr_full;
                aw_rdy = m_axi_awready && !wr_full;
            end else begin
                aw_rdy  = 1'b1;
                aw_viol = 1'b1;
            end
        end
    end

    assign push          = s_axi_awvalid && aw_rdy;
    assign m_axi_awvalid = aw_vld;
    assign s_axi_awready = aw_rdy;
    assign m_axi_wvalid  = w_vld;
    assign s_axi_wready  = w_rdy;
    assign m_axi_bready  = b_rdy;

    logic wr_inc, wr_dec;
    assign wr_inc = aw_vld && m_axi_awready;
    assign wr_dec = m_axi_bvalid && b_rdy;

    always_comb begin
        wr_outs_d = wr_outs_q;
        if (wr_inc && !wr_dec) wr_outs_d = wr_outs_q + OUTS_W'(1);
        if (!wr_inc && wr_dec) wr_outs_d = wr_outs_q - OUTS_W'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_state_q <= PASS;
            wr_outs_q  <= '0;
            wr_id_q    <= '0;
            fifo_blk_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
            for (int i = 0; i < WQ_DEPTH; i++) fifo_id_q[i] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_outs_q  <= wr_outs_d;
            wr_id_q    <= wr_id_d;
            if (push) begin
                fifo_blk_q[wptr_q] <= !aw_legal;
                fifo_id_q[wptr_q]  <= s_axi_awid;
                wptr_q             <= wptr_q + PTR_W'(1);
            end
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            if (push && !pop) fcnt_q <= fcnt_q + (PTR_W+1)'(1);
            if (!push && pop) fcnt_q <= fcnt_q - (PTR_W+1)'(1);
        end
    end

`ifdef DMA_GUARD_ERRLOG_EN
    logic              err_irq_q, err_is_wr_q;
    logic [ADDR_W-1:0] err_addr_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_irq_q   <= 1'b0;
            err_is_wr_q <= 1'b0;
            err_addr_q  <= '0;
        end else if ((ar_viol || aw_viol) && (!err_irq_q || err_clr)) begin
            err_irq_q   <= 1'b1;
            err_is_wr_q <= !ar_viol;
            err_addr_q  <= ar_viol ? s_axi_araddr : s_axi_awaddr;
        end else if (err_clr) begin
            err_irq_q <= 1'b0;
        end
    end

    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;
    assign err_is_wr = err_is_wr_q;
`else
    logic unused_viol;
    assign unused_viol = ar_viol ^ aw_viol;
`endif

endmodule

// File: tb/tb_dma_window_guard.sv
// Directed self-checking bench for dma_window_guard.
// Define DMA_GUARD_ERRLOG_EN to also exercise the error log.
module tb_dma_window_guard;
    import dma_guard_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

`ifdef DMA_GUARD_ERRLOG_EN
    logic        err_clr = 1'b0;
    logic        err_irq, err_is_wr;
    logic [39:0] err_addr;
`endif
    logic [39:0] s_axi_awaddr, s_axi_araddr, m_axi_awaddr, m_axi_araddr;
    logic [7:0]  s_axi_awlen, s_axi_arlen, m_axi_awlen, m_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize, m_axi_awsize, m_axi_arsize;
    logic [1:0]  s_axi_awburst, s_axi_arburst, m_axi_awburst, m_axi_arburst;
    logic        s_axi_awlock, s_axi_arlock, m_axi_awlock, m_axi_arlock;
    logic [3:0]  s_axi_awcache, s_axi_arcache, m_axi_awcache, m_axi_arcache;
    logic [2:0]  s_axi_awprot, s_axi_arprot, m_axi_awprot, m_axi_arprot;
    logic [3:0]  s_axi_awqos, s_axi_arqos, m_axi_awqos, m_axi_arqos;
    logic [15:0] s_axi_awid, s_axi_arid, m_axi_awid, m_axi_arid;
    logic [15:0] s_axi_awuser, s_axi_aruser, m_axi_awuser, m_axi_aruser;
    logic        s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
    logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
    logic [63:0] s_axi_wdata, m_axi_wdata, s_axi_rdata, m_axi_rdata;
    logic [7:0]  s_axi_wstrb, m_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [15:0] s_axi_bid, m_axi_bid, s_axi_rid, m_axi_rid;
    logic [1:0]  s_axi_bresp, m_axi_bresp, s_axi_rresp, m_axi_rresp;
    logic        s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    dma_window_guard dut (
        .aclk(aclk), .aresetn(aresetn),
`ifdef DMA_GUARD_ERRLOG_EN
        .err_clr(err_clr), .err_irq(err_irq),
        .err_addr(err_addr), .err_is_wr(err_is_wr),
`endif
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
        .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awid(s_axi_awid), .s_axi_awuser(s_axi_awuser),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
        .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arid(s_axi_arid), .s_axi_aruser(s_axi_aruser),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awid(m_axi_awid), .m_axi_awuser(m_axi_awuser),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arid(m_axi_arid), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_ar(input logic [39:0] a, input logic [7:0] l,
                            input logic [15:0] id);
        s_axi_araddr  = a;
        s_axi_arlen   = l;
        s_axi_arsize  = 3'd3;
        s_axi_arburst = BURST_INCR;
        s_axi_arid    = id;
        s_axi_arvalid = 1'b1;
    endtask

    task automatic drive_aw(input logic [39:0] a, input logic [7:0] l,
                            input logic [15:0] id);
        s_axi_awaddr  = a;
        s_axi_awlen   = l;
        s_axi_awsize  = 3'd3;
        s_axi_awburst = BURST_INCR;
        s_axi_awid    = id;
        s_axi_awvalid = 1'b1;
    endtask

    // Entered ~2ns after an edge with s_axi_rready high.
    task automatic expect_err_r(input int beats, input logic [15:0] id);
        int n;
        for (int b = 0; b < beats; b++) begin
            n = 0;
            while (s_axi_rvalid !== 1'b1 && n < 20) begin
                tick(); #1; n++;
            end
            check_eq("err_r_valid", 64'(s_axi_rvalid), 64'd1);
            check_eq("err_r_data", s_axi_rdata, 64'd0);
            check_eq("err_r_resp", 64'(s_axi_rresp), 64'd3);
            check_eq("err_r_id", 64'(s_axi_rid), 64'(id));
            check_eq("err_r_last", 64'(s_axi_rlast), 64'(b == beats - 1));
            tick(); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs;
        s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = BURST_INCR; s_axi_awlock = 1'b0;
        s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0;
        s_axi_awid = '0; s_axi_awuser = '0; s_axi_awvalid = 1'b0;
        s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = BURST_INCR; s_axi_arlock = 1'b0;
        s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0;
        s_axi_arid = '0; s_axi_aruser = '0; s_axi_arvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = 8'hFF; s_axi_wlast = 1'b0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        m_axi_rdata = '0; m_axi_rid = '0; m_axi_rresp = '0;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

        repeat (3) @(posedge aclk);
        #2;
        check_eq("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check_eq("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check_eq("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check_eq("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        check_eq("rst_wready", 64'(s_axi_wready), 64'd0);
        aresetn = 1'b1;
        tick();

        // Legal INCR read passes through unchanged
        drive_ar(40'h10_0000_0000, 8'd3, 16'd7);
        #1;
        check_eq("ar_fwd_valid", 64'(m_axi_arvalid), 64'd1);
        check_eq("ar_fwd_ready", 64'(s_axi_arready), 64'd1);
        check_eq("ar_fwd_addr", 64'(m_axi_araddr), 64'h10_0000_0000);
        check_eq("ar_fwd_len", 64'(m_axi_arlen), 64'd3);
        check_eq("ar_fwd_id", 64'(m_axi_arid), 64'd7);
        tick();
        s_axi_arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'hA0 + 64'(i);
            m_axi_rid    = 16'd7;
            m_axi_rlast  = (i == 3);
            #1;
            check_eq("r_pass_data", s_axi_rdata, 64'hA0 + 64'(i));
            check_eq("r_pass_id", 64'(s_axi_rid), 64'd7);
            check_eq("r_pass_last", 64'(s_axi_rlast), 64'(i == 3));
            tick();
        end
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;

        // Read crossing the window top
        drive_ar(40'h10_7FFF_FFF8, 8'd1, 16'd9);
        #1;
        check_eq("ar_bad_fwd", 64'(m_axi_arvalid), 64'd0);
        check_eq("ar_bad_ready", 64'(s_axi_arready), 64'd1);
        tick();
        s_axi_arvalid = 1'b0;
        #1;
        expect_err_r(2, 16'd9);
        check_eq("r_err_done", 64'(s_axi_rvalid), 64'd0);

        // Legal then illegal write on the same id
        drive_aw(40'h10_0000_1000, 8'd0, 16'd5);
        #1;
        check_eq("aw_fwd_valid", 64'(m_axi_awvalid), 64'd1);
        check_eq("aw_fwd_ready", 64'(s_axi_awready), 64'd1);
        tick();
        drive_aw(40'h00_0000_0000, 8'd3, 16'd5);
        #1;
        check_eq("aw_bad_fwd", 64'(m_axi_awvalid), 64'd0);
        check_eq("aw_bad_ready", 64'(s_axi_awready), 64'd1);
        tick();
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b1;
        s_axi_wdata   = 64'h55;
        s_axi_wlast   = 1'b1;
        #1;
        check_eq("w_pass_valid", 64'(m_axi_wvalid), 64'd1);
        check_eq("w_pass_data", m_axi_wdata, 64'h55);
        check_eq("w_pass_ready", 64'(s_axi_wready), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            s_axi_wdata = 64'h100 + 64'(i);
            s_axi_wlast = (i == 3);
            #1;
            check_eq("w_drain_fwd", 64'(m_axi_wvalid), 64'd0);
            check_eq("w_drain_ready", 64'(s_axi_wready), 64'd1);
            tick();
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        #1;
        check_eq("b_wait_legal", 64'(s_axi_bvalid), 64'd0);
        m_axi_bvalid = 1'b1;
        m_axi_bid    = 16'd5;
        m_axi_bresp  = RESP_OKAY;
        #1;
        check_eq("b1_valid", 64'(s_axi_bvalid), 64'd1);
        check_eq("b1_id", 64'(s_axi_bid), 64'd5);
        check_eq("b1_resp", 64'(s_axi_bresp), 64'd0);
        tick();
        m_axi_bvalid = 1'b0;
        #1;
        n = 0;
        while (s_axi_bvalid !== 1'b1 && n < 20) begin
            tick(); #1; n++;
        end
        check_eq("b2_valid", 64'(s_axi_bvalid), 64'd1);
        check_eq("b2_id", 64'(s_axi_bid), 64'd5);
        check_eq("b2_resp", 64'(s_axi_bresp), 64'd3);
        tick();
        #1;
        check_eq("b2_done", 64'(s_axi_bvalid), 64'd0);
        s_axi_wvalid = 1'b1;
        #1;
        check_eq("w_empty_ready", 64'(s_axi_wready), 64'd0);
        check_eq("w_empty_fwd", 64'(m_axi_wvalid), 64'd0);
        s_axi_wvalid = 1'b0;

        // Fill the AW FIFO
        for (int i = 0; i < 8; i++) begin
            drive_aw(40'h10_0000_2000 + 40'(i * 64), 8'd0, 16'(i));
            tick();
        end
        drive_aw(40'h10_0000_3000, 8'd0, 16'd8);
        #1;
        check_eq("aw_full_ready", 64'(s_axi_awready), 64'd0);
        check_eq("aw_full_fwd", 64'(m_axi_awvalid), 64'd0);
        tick();
        check_eq("aw_full_hold", 64'(s_axi_awready), 64'd0);
        s_axi_wvalid = 1'b1;
        s_axi_wlast  = 1'b1;
        #1;
        check_eq("aw_full_pop", 64'(s_axi_awready), 64'd1);
        check_eq("aw_full_w", 64'(m_axi_wvalid), 64'd1);
        tick();
        s_axi_wvalid  = 1'b0;
        s_axi_wlast   = 1'b0;
        s_axi_awvalid = 1'b0;

        // Backpressured DECERR read, reset mid-burst
        drive_ar(40'h00_0000_0000, 8'd3, 16'd3);
        tick();
        s_axi_arvalid = 1'b0;
        #1;
        n = 0;
        while (s_axi_rvalid !== 1'b1 && n < 20) begin
            tick(); #1; n++;
        end
        hs = 0;
        for (int c = 0; c < 7; c++) begin
            s_axi_rready = (c % 2 == 1);
            #1;
            check_eq("r_bp_valid", 64'(s_axi_rvalid), 64'd1);
            check_eq("r_bp_last", 64'(s_axi_rlast), 64'(hs == 3));
            tick(); #1;
            if (c % 2 == 1) hs++;
        end
        aresetn = 1'b0;
        #1;
        check_eq("rst_mid_rvalid", 64'(s_axi_rvalid), 64'd0);
        check_eq("rst_mid_wready", 64'(s_axi_wready), 64'd0);
        s_axi_rready = 1'b1;
        tick();
        aresetn = 1'b1;
        drive_ar(40'h10_0000_0040, 8'd0, 16'd4);
        #1;
        check_eq("ar_after_rst", 64'(m_axi_arvalid), 64'd1);
        check_eq("ar_after_rdy", 64'(s_axi_arready), 64'd1);
        tick();
        s_axi_arvalid = 1'b0;
        m_axi_rvalid  = 1'b1;
        m_axi_rid     = 16'd4;
        m_axi_rdata   = 64'hBEEF;
        m_axi_rlast   = 1'b1;
        #1;
        check_eq("r_after_rst", s_axi_rdata, 64'hBEEF);
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        #1;

`ifdef DMA_GUARD_ERRLOG_EN
        check_eq("log_rst_irq", 64'(err_irq), 64'd0);
        drive_ar(40'h00_0000_0000, 8'd0, 16'd1);
        tick();
        s_axi_arvalid = 1'b0;
        #1;
        expect_err_r(1, 16'd1);
        drive_ar(40'h20_0000_0000, 8'd0, 16'd2);
        tick();
        s_axi_arvalid = 1'b0;
        #1;
        expect_err_r(1, 16'd2);
        check_eq("log_addr_first", 64'(err_addr), 64'd0);
        check_eq("log_irq", 64'(err_irq), 64'd1);
        check_eq("log_is_wr_rd", 64'(err_is_wr), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1;
        check_eq("log_clr", 64'(err_irq), 64'd0);
        drive_aw(40'h20_0000_0000, 8'd0, 16'd6);
        tick();
        s_axi_awvalid = 1'b0;
        #1;
        check_eq("log_irq2", 64'(err_irq), 64'd1);
        check_eq("log_addr2", 64'(err_addr), 64'h20_0000_0000);
        check_eq("log_is_wr_wr", 64'(err_is_wr), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
